// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the FIR output conditioning stage.
package fir_pkg;

  localparam int FIR_W = 26;

  typedef logic signed [FIR_W-1:0] sample_t;

  function automatic logic signed [63:0] sat_limit(
    input int width,
    input bit is_max
  );
    logic signed [63:0] one;
    one = 64'sd1;
    if (is_max) return (one <<< (width - 1)) - 64'sd1;
    return -(one <<< (width - 1));
  endfunction

  function automatic bit params_ok(
    input int iw,
    input int ow,
    input int drop,
    input int decim,
    input int phase
  );
    return (drop >= 1) && (iw - drop >= ow) &&
           (iw - drop + 1 <= 64) &&
           (decim >= 1) && (phase >= 0) &&
           (phase < decim);
  endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up (stage 1 input) and
// saturation with sat flag (stage 2 input).
module round_sat
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DROP_LSB     = 10
) (
  input  logic [INPUT_WIDTH-1:0]        din,
  output logic [INPUT_WIDTH-DROP_LSB:0] r,
  input  logic [INPUT_WIDTH-DROP_LSB:0] r_in,
  output logic [OUTPUT_WIDTH-1:0]       dout,
  output logic                          sat
);

  localparam int RW = INPUT_WIDTH - DROP_LSB + 1;
  localparam int XW = 64 - RW;

  localparam logic [INPUT_WIDTH:0] HALF =
    (INPUT_WIDTH+1)'(1) << (DROP_LSB - 1);

  localparam logic signed [63:0] MAXV =
    sat_limit(OUTPUT_WIDTH, 1'b1);
  localparam logic signed [63:0] MINV =
    sat_limit(OUTPUT_WIDTH, 1'b0);

  logic [INPUT_WIDTH:0] sum;
  logic signed [63:0]   rx;
  logic                 hi;
  logic                 lo;
  logic                 unused_lsb;

  // one extra bit of headroom so the half-LSB add never wraps
  assign sum = {din[INPUT_WIDTH-1], din} + HALF;
  assign r   = sum[INPUT_WIDTH:DROP_LSB];

  assign unused_lsb = ^sum[DROP_LSB-1:0];

  assign rx = {{XW{r_in[RW-1]}}, r_in};

  always_comb begin
    hi   = rx > MAXV;
    lo   = rx < MINV;
    sat  = hi | lo;
    dout = rx[OUTPUT_WIDTH-1:0];
    if (hi) dout = MAXV[OUTPUT_WIDTH-1:0];
    else if (lo) dout = MINV[OUTPUT_WIDTH-1:0];
  end

endmodule

// File: rtl/fir_decim_quant.sv
// Decimate, round and saturate the FIR output stream.
// Sticky overflow flag built only with FIR_DECIM_QUANT_OVF_EN.
module fir_decim_quant
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DROP_LSB     = 10,
  parameter int DECIM        = 4,
  parameter int PHASE        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic                    valid_out,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int RW = INPUT_WIDTH - DROP_LSB + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);
  localparam logic [CW-1:0] PH   = CW'(PHASE);

  if (!params_ok(INPUT_WIDTH, OUTPUT_WIDTH,
                 DROP_LSB, DECIM, PHASE)) begin : g_bad
    $error("fir_decim_quant: illegal DROP_LSB/DECIM/PHASE");
  end

  logic [CW-1:0]           cnt;
  logic                    keep;
  logic                    v1;
  logic [RW-1:0]           r1;
  logic [RW-1:0]           rnd;
  logic [OUTPUT_WIDTH-1:0] sat_dout;
  logic                    sat;

  assign keep = valid_in && (cnt == PH);

  // LAST is 0 when DECIM is 1, which pins cnt at 0
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (valid_in) begin
      if (cnt == LAST) cnt <= '0;
      else cnt <= cnt + CW'(1);
    end
  end

  round_sat #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .DROP_LSB    (DROP_LSB)
  ) u_round_sat (
    .din (din),
    .r   (rnd),
    .r_in(r1),
    .dout(sat_dout),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else begin
      v1 <= keep;
      if (keep) r1 <= rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out <= 1'b0;
      dout      <= '0;
    end else begin
      valid_out <= v1;
      if (v1) dout <= sat_dout;
    end
  end

`ifdef FIR_DECIM_QUANT_OVF_EN
  // set wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!rst) ovf <= 1'b0;
    else if (v1 && sat) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ sat;
  assign ovf        = 1'b0;
`endif

endmodule

// File: doc/fir_decim_quant.md
# fir_decim_quant

Output-conditioning stage placed directly downstream of the FIR filter. It takes the filter's full-width output stream (`valid_in`/`din`) and keeps one of every `DECIM` valid samples. Kept samples are rounded to the nearest value by dropping `DROP_LSB` LSBs, then saturated to `OUTPUT_WIDTH`. The result is a two-stage registered stream with a sticky overflow indication.

## Interface
Parameters:
- `INPUT_WIDTH`, 26: width of the signed FIR output consumed.
- `OUTPUT_WIDTH`, 16: width of the signed output produced.
- `DROP_LSB`, 10: LSBs removed by rounding. Must be ≥ 1. `INPUT_WIDTH - DROP_LSB ≥ OUTPUT_WIDTH` is required.
- `DECIM`, 4: decimation ratio. Must be ≥ 1; 1 passes every sample.
- `PHASE`, 0: index of the kept sample within each group of `DECIM`. Must satisfy 0 ≤ `PHASE` < `DECIM`.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-low reset (0 = reset).
- `valid_in`, in, 1: `din` is valid this cycle. No backpressure.
- `din`, in, `INPUT_WIDTH`: signed sample from the FIR.
- `valid_out`, out, 1: `dout` is valid this cycle (one-cycle strobe per kept sample).
- `dout`, out, `OUTPUT_WIDTH`: signed, rounded, saturated sample.
- `ovf`, out, 1: sticky saturation flag.
- `ovf_clr`, in, 1: synchronous clear of `ovf`.

## Operation
- Phase counter `cnt`, range 0..`DECIM-1`:
  - Increments only when `valid_in` = 1 and wraps from `DECIM-1` to 0.
  - Idle cycles (`valid_in` = 0) do not advance it.
  - A sample is kept when `valid_in` = 1 and `cnt` == `PHASE`.
  - When `DECIM` = 1, the counter is constant 0 and every valid sample is kept.
- Stage 1 (registered) rounds the kept sample:
  - `r = (sext(din, INPUT_WIDTH+1) + 2^(DROP_LSB-1)) >>> DROP_LSB`.
  - This is round half up, i.e. ties go toward +∞.
  - The add is done at `INPUT_WIDTH+1` bits, so it never wraps.
- Stage 2 (registered) saturates `r`:
  - If `r > 2^(OUTPUT_WIDTH-1)-1`, output `0x7FF…F`.
  - If `r < -2^(OUTPUT_WIDTH-1)`, output `0x80…0`.
  - Otherwise output the LSBs of `r` unchanged.
  - A saturation event asserts a one-cycle internal `sat` pulse together with `valid_out`.
- `ovf` behaviour:
  - Set on a `sat` pulse.
  - Cleared by `ovf_clr`.
  - If a `sat` pulse and `ovf_clr` occur in the same cycle, set wins.
- Reset mid-stream:
  - Clears `cnt`, both stage valids, `dout`, and `ovf` on the next edge.
  - Samples in flight are discarded, never emitted.
  - The first valid sample after reset release has index 0.

## Timing
- Reset values: `valid_out` = 0, `dout` = 0, `ovf` = 0, `cnt` = 0.
- Latency is 2 cycles: a kept sample presented at edge N gives `valid_out`/`dout` after edge N+2.
- Throughput: one kept sample per cycle at `DECIM` = 1. No stalls are possible.
- `dout` holds its last value while `valid_out` = 0.
- `ovf` rises at the same edge where the saturating sample's `valid_out` rises.

## Configuration
- `FIR_DECIM_QUANT_OVF_EN`:
  - Defined: the `ovf` sticky logic and the `ovf_clr` input are functional.
  - Undefined: no saturation-detect flop is built, `ovf` is tied to 0, and `ovf_clr` is ignored.
  - Saturation of `dout` is identical in both builds.

## Structure
- Package `fir_pkg`:
  - Typedef `sample_t` for the signed FIR sample.
  - Function `sat_limit(width, is_max)` returning the signed max/min constants.
  - Parameter-check function used in an elaboration-time `$error` for illegal `DROP_LSB`/`DECIM`/`PHASE`.
- One sub-module, `round_sat`, holds the combinational round and saturate logic plus the `sat` output. The top keeps the counter, pipeline registers and `ovf`.

## Test plan
All scenarios use the default parameters.
- **Rounding ties:**
  - `din` = 1536 (1.5 LSB) → `dout` = 2.
  - `din` = −1536 → `dout` = −1.
  - `din` = 511 → `dout` = 0.
  - `ovf` stays 0 throughout.
- **Saturation:**
  - `din` = 0x1FFFFFF → `dout` = 0x7FFF, `ovf` = 1.
  - `din` = 0x2000000 → `dout` = 0x8000 with no new saturation.
  - After `ovf_clr`, `ovf` = 0.
  - A saturating sample in the same cycle as `ovf_clr` → `ovf` = 1.
- **Decimation:** 12 consecutive valid samples `din` = k·1024, k = 0..11 → exactly 3 strobes, `dout` = 0, 4, 8. The first strobe comes 2 cycles after k = 0.
- **Gapped input:** the same 12 samples with `valid_in` deasserted on alternate cycles → the same outputs 0, 4, 8, with the strobe spacing doubled.
- **Reset mid-stream:**
  - Assert `rst` = 0 for 1 cycle right after sample k = 5.
  - Expected: no strobe for in-flight samples and all outputs at reset values.
  - The next samples k = 6..9 → single strobe `dout` = 6.
- **Macro off:** rerun the saturation scenario without `FIR_DECIM_QUANT_OVF_EN` → `dout` = 0x7FFF, `ovf` constantly 0.
